// File: rtl/instr_fetch_unit.sv
// Fetch stage front end: issues PC addresses to a synchronous instruction memory and
// queues returned words in a small FIFO that feeds the ID stage over valid/ready.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    output logic                  stall,
    input  logic                  flush,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_instruction,
    output logic [ADDR_WIDTH-1:0] id_pc,
    input  logic                  id_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      occupancy;
    logic                  inflight;
    logic                  pop;
    logic                  push;
    logic                  space;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // Queued plus in-flight words must leave room for one more; a same-cycle pop frees a slot.
    assign id_valid  = (count != '0);
    assign pop       = id_valid & id_ready;
    assign occupancy = count + CNT_W'(inflight) - CNT_W'(pop);
    assign space     = occupancy < DEPTH_C;

    // Holding reset forces stall high even if flush happens to be asserted alongside it.
    assign imem_en   = reset & ~flush & space;
    assign stall     = ~reset | (~imem_en & ~flush);
    assign imem_addr = instruction_address;

    assign push           = inflight & ~flush;
    assign id_instruction = data_q[head];
    assign id_pc          = pc_q[head];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            req_pc   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                req_pc <= instruction_address;
            end
            if (flush) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                if (push) begin
                    data_q[tail] <= imem_rdata;
                    pc_q[tail]   <= req_pc;
                    tail         <= next_ptr(tail);
                end
                if (pop) begin
                    head <= next_ptr(head);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a PC model reacting to stall, a memory model
// returning 0x1000+addr, and a queue of presented addresses checked at every ID handshake.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        id_ready;
    logic [31:0] instruction_address;

    logic        stall2, en2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2;
    logic        stall4, en4, valid4;
    logic [31:0] addr4, rdata4, instr4, pc4;

    logic        sel;
    logic [31:0] s_valid, s_stall, s_en, s_pc, s_instr, s_addr;
    logic [31:0] pc;
    logic        pc_new;
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc;
    int          tests;
    int          fails;
    int          pop_count;

    instr_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2)) dut2 (
        .clock(clock), .reset(reset), .instruction_address(instruction_address),
        .stall(stall2), .flush(flush), .imem_en(en2), .imem_addr(addr2),
        .imem_rdata(rdata2), .id_valid(valid2), .id_instruction(instr2),
        .id_pc(pc2), .id_ready(id_ready)
    );

    instr_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut4 (
        .clock(clock), .reset(reset), .instruction_address(instruction_address),
        .stall(stall4), .flush(flush), .imem_en(en4), .imem_addr(addr4),
        .imem_rdata(rdata4), .id_valid(valid4), .id_instruction(instr4),
        .id_pc(pc4), .id_ready(id_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (en2) rdata2 <= 32'h1000 + addr2;
        if (en4) rdata4 <= 32'h1000 + addr4;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle as seen by the PC: present an address, sample after inputs settle,
    // score any handshake, then move the PC the way a real PC would react to stall/flush.
    task automatic apply_stimulus(input logic fl, input logic rdy, input logic [31:0] target);
        if (pc_new) exp_q.push_back(pc);
        instruction_address = pc;
        flush               = fl;
        id_ready            = rdy;
        #1;
        if (sel) begin
            s_valid = {31'b0, valid4}; s_stall = {31'b0, stall4}; s_en = {31'b0, en4};
            s_pc = pc4; s_instr = instr4; s_addr = addr4;
        end else begin
            s_valid = {31'b0, valid2}; s_stall = {31'b0, stall2}; s_en = {31'b0, en2};
            s_pc = pc2; s_instr = instr2; s_addr = addr2;
        end
        check_output("imem_addr", s_addr, instruction_address);
        if (s_valid[0] && rdy) begin
            pop_count++;
            check_output("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check_output("sb_pc", s_pc, exp_pc);
                check_output("sb_instr", s_instr, 32'h1000 + exp_pc);
            end
        end
        if (fl) begin
            exp_q.delete();
            pc     = target;
            pc_new = 1'b1;
        end else if (s_stall[0] == 1'b0) begin
            pc     = pc + 1;
            pc_new = 1'b1;
        end else begin
            pc_new = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic release_reset();
        reset  = 1'b1;
        flush  = 1'b0;
        exp_q.delete();
        pc     = 32'd0;
        pc_new = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0; pop_count = 0;
        reset = 1'b0; flush = 1'b0; id_ready = 1'b0; instruction_address = '0;
        sel = 1'b0; pc = '0; pc_new = 1'b1;

        // Reset state
        @(negedge clock);
        #1;
        check_output("rst_valid", {31'b0, valid2}, 32'd0);
        check_output("rst_stall", {31'b0, stall2}, 32'd1);
        check_output("rst_en", {31'b0, en2}, 32'd0);
        check_output("rst_pc", pc2, 32'd0);
        check_output("rst_instr", instr2, 32'd0);
        check_output("rst_valid4", {31'b0, valid4}, 32'd0);
        @(negedge clock);
        release_reset();

        // Streaming with id_ready high: two-cycle latency, then one per cycle
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t1_c0_valid", s_valid, 32'd0);
        check_output("t1_c0_en", s_en, 32'd1);
        check_output("t1_c0_stall", s_stall, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t1_c1_valid", s_valid, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t1_c2_valid", s_valid, 32'd1);
        check_output("t1_c2_pc", s_pc, 32'd0);
        check_output("t1_c2_instr", s_instr, 32'h1000);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 32'd0);
            check_output("t1_stall", s_stall, 32'd0);
            check_output("t1_valid", s_valid, 32'd1);
        end

        // Backpressure with DEPTH=2
        hold_reset();
        release_reset();
        apply_stimulus(1'b0, 1'b0, 32'd0);
        check_output("t2_a0_stall", s_stall, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        check_output("t2_a1_stall", s_stall, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        check_output("t2_a2_stall", s_stall, 32'd1);
        check_output("t2_a2_pc", s_pc, 32'd0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'd0);
            check_output("t2_hold_stall", s_stall, 32'd1);
            check_output("t2_hold_pc", s_pc, 32'd0);
            check_output("t2_hold_instr", s_instr, 32'h1000);
        end
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t2_drain_stall", s_stall, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t2_second_pc", s_pc, 32'd1);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t2_third_pc", s_pc, 32'd2);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 32'd0);

        // Flush with 3,4 queued and 5 in flight (DEPTH=4)
        sel = 1'b1;
        hold_reset();
        release_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        check_output("t3_pre_pc", s_pc, 32'd3);
        apply_stimulus(1'b1, 1'b0, 32'h40);
        check_output("t3_fl_en", s_en, 32'd0);
        check_output("t3_fl_stall", s_stall, 32'd0);
        check_output("t3_fl_pc", s_pc, 32'd3);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t3_post_valid", s_valid, 32'd0);
        check_output("t3_post_en", s_en, 32'd1);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t3_lat_valid", s_valid, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t3_redir_valid", s_valid, 32'd1);
        check_output("t3_redir_pc", s_pc, 32'h40);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 32'd0);

        // Flush coincident with a pop of head 3 (DEPTH=2)
        sel = 1'b0;
        hold_reset();
        release_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'h80);
        check_output("t4_fl_pc", s_pc, 32'd3);
        check_output("t4_fl_en", s_en, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t4_c1_valid", s_valid, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t4_c2_valid", s_valid, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t4_redir_valid", s_valid, 32'd1);
        check_output("t4_redir_pc", s_pc, 32'h80);

        // Asynchronous reset with the FIFO full
        hold_reset();
        release_reset();
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        check_output("t5_full_stall", s_stall, 32'd1);
        check_output("t5_full_valid", s_valid, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_output("t5_async_valid", {31'b0, valid2}, 32'd0);
        check_output("t5_async_en", {31'b0, en2}, 32'd0);
        check_output("t5_async_stall", {31'b0, stall2}, 32'd1);
        check_output("t5_async_pc", pc2, 32'd0);
        @(negedge clock);
        @(negedge clock);
        release_reset();
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t5_c0_valid", s_valid, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t5_c1_valid", s_valid, 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0);
        check_output("t5_c2_valid", s_valid, 32'd1);
        check_output("t5_c2_instr", s_instr, 32'h1000);

        // DEPTH=4 with id_ready toggling: ordering held by the scoreboard
        sel = 1'b1;
        hold_reset();
        release_reset();
        pop_count = 0;
        for (int i = 0; i < 40; i++) apply_stimulus(1'b0, (i % 2) == 0, 32'd0);
        check_output("t6_pops", 32'(pop_count), 32'd19);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
